seg_to_bcd_capture: RTL and testbench
=====================================

SEG_TO_BCD_CAPTURE -- requirements
Module: seg_to_bcd_capture

Interface
REQ-001 SHALL have parameter STABLE, default 4, the number of consecutive identical samples required before a digit is committed; legal range 2..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port seg, input, 7, active-high segment lines, bit6=a … bit0=g.
REQ-005 SHALL have port dig_sel, input, 4, active-high one-hot digit enable; bit3 is the most significant digit, bit0 the least.
REQ-006 SHALL have port err_clr, input, 1, a one-cycle pulse that clears err.
REQ-007 SHALL have port bcd, output, 16, captured digits; bcd[4k+3:4k] holds digit k.
REQ-008 SHALL have port valid, output, 4, per-digit flag meaning bcd slice k holds a legal decoded value.
REQ-009 SHALL have port all_valid, output, 1, the AND of valid[3:0].
REQ-010 SHALL have port upd, output, 1, a one-cycle pulse for every commit (legal, blank or illegal).
REQ-011 SHALL have port err, output, 1, sticky flag set when an illegal pattern is committed.

Function
REQ-012 SHALL decode seg as 0x7E→0, 0x30→1, 0x6D→2, 0x79→3, 0x33→4, 0x5B→5, 0x1F→6, 0x70→7, 0x7F→8, 0x73→9.
REQ-013 SHALL treat 0x00 as blank; every other pattern is illegal.
REQ-014 SHALL register {dig_sel,seg} into prev every cycle.
REQ-015 SHALL maintain cnt: it loads 1 when the inputs differ from prev, increments saturating at STABLE when they match, and loads 0 when dig_sel is not exactly one-hot.
REQ-016 SHALL commit on the edge where the inputs match prev, cnt==STABLE-1 and dig_sel is one-hot. Inputs held for STABLE consecutive edges commit on the STABLE-th edge; with STABLE=4, inputs applied before edge 0 commit at edge 3.
REQ-017 SHALL commit exactly once per stable run; a run longer than STABLE produces no further commits.
REQ-018 Legal commit: bcd slice k <= decoded value and valid[k] <= 1, where k is the index of the set dig_sel bit.
REQ-019 Blank commit: valid[k] <= 0, bcd slice k unchanged, err unchanged.
REQ-020 Illegal commit: valid[k] <= 0, bcd slice k unchanged, err <= 1.
REQ-021 upd SHALL be high for exactly the cycle following the commit edge.
REQ-022 When err_clr and an illegal commit occur on the same edge, err SHALL be 1 (set wins).
REQ-023 dig_sel zero or multi-hot SHALL produce no commit and no state change other than prev and cnt; it is not an error.
REQ-024 A change of only seg, or only dig_sel, SHALL restart the run (cnt <= 1).
REQ-025 all_valid SHALL be combinational from the valid register, with no extra latency.

Reset
REQ-026 While rst=1 at an edge, bcd, valid, upd, err, cnt and prev SHALL all be set to 0; all_valid therefore reads 0.
REQ-027 Reset asserted mid-run SHALL discard the partial run; the first post-reset commit needs STABLE fresh identical samples.

Structure
REQ-028 A shared package SHALL hold the ten digit pattern constants, SEG_BLANK = 7'h00, and NDIG = 4; these are shared with the display encoder.
REQ-029 The decode table SHALL be a combinational sub-module seg2bcd (seg in; bcd[3:0] and legal/blank flags out); the capture block instantiates it once.

Verification
REQ-030 STABLE=4; hold dig_sel=0001, seg=0x5B for 6 cycles → one upd pulse after edge 3; bcd[3:0]=5; valid=0001; no second upd.
REQ-031 Scan 0x30, 0x6D, 0x79, 0x33 across dig_sel 1000, 0100, 0010, 0001, each held 5 cycles → bcd=16'h1234; all_valid=1; 4 upd pulses.
REQ-032 Hold seg=0x7E for 3 cycles, toggle to 0x7F for 1 cycle, then back to 0x7E for 4 cycles → only the final run commits: digit=0, one upd.
REQ-033 Commit 0x7F then 0x6F on the same digit → digit stays 8, valid[k]=0, err=1; then pulse err_clr → err=0.
REQ-034 dig_sel=0011 for 10 cycles → no upd; valid unchanged. Then dig_sel=0000, seg=0x00 → no upd.
REQ-035 Assert rst at the cycle where cnt==2, then resume the same inputs → outputs are 0 after reset, and the commit occurs exactly STABLE edges after rst deasserts.

Source files
------------

// File: rtl/seg_to_bcd_capture_pkg.sv
// seg_to_bcd_capture_pkg: digit patterns and sizes shared by the capture block and the display encoder
package seg_to_bcd_capture_pkg;
    localparam int NDIG = 4;
    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h1F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h73;
    localparam logic [6:0] SEG_BLANK = 7'h00;
endpackage

// File: rtl/seg2bcd.sv
// seg2bcd: combinational 7-segment (a..g = bit6..bit0) to BCD decoder
// Ports: seg in; bcd decoded digit, legal = known digit, blank = all segments off
module seg2bcd
    import seg_to_bcd_capture_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       legal,
    output logic       blank
);
    always_comb begin
        bcd = 4'd0;
        legal = 1'b1;
        case (seg)
            SEG_0: bcd = 4'd0;
            SEG_1: bcd = 4'd1;
            SEG_2: bcd = 4'd2;
            SEG_3: bcd = 4'd3;
            SEG_4: bcd = 4'd4;
            SEG_5: bcd = 4'd5;
            SEG_6: bcd = 4'd6;
            SEG_7: bcd = 4'd7;
            SEG_8: bcd = 4'd8;
            SEG_9: bcd = 4'd9;
            default: legal = 1'b0;
        endcase
    end
    assign blank = seg == SEG_BLANK;
endmodule

// File: rtl/seg_to_bcd_capture.sv
// seg_to_bcd_capture: debounced capture of a scanned 7-segment display into per-digit BCD
// Ports: clk, rst (sync, active-high); seg/dig_sel scanned inputs; err_clr clears err;
//        bcd/valid captured digits, all_valid, upd commit pulse, err sticky illegal-pattern flag
module seg_to_bcd_capture
    import seg_to_bcd_capture_pkg::*;
#(
    parameter int STABLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  dig_sel,
    input  logic        err_clr,
    output logic [15:0] bcd,
    output logic [3:0]  valid,
    output logic        all_valid,
    output logic        upd,
    output logic        err
);
    localparam logic [3:0] STB = 4'(STABLE);
    logic [10:0] prev_q, prev_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  valid_q, valid_d;
    logic        upd_q, upd_d, err_q, err_d;
    logic        onehot, match, commit;
    logic [3:0]  dec;
    logic        legal, blank;
    seg2bcd u_dec (
        .seg  (seg),
        .bcd  (dec),
        .legal(legal),
        .blank(blank)
    );
    always_comb begin
        prev_d = {dig_sel, seg};
        onehot = (dig_sel != 4'd0) && ((dig_sel & (dig_sel - 4'd1)) == 4'd0);
        match = prev_d == prev_q;
        // cnt saturates at STABLE so a long run commits only once
        cnt_d = !onehot ? 4'd0 : !match ? 4'd1 : (cnt_q == STB) ? STB : cnt_q + 4'd1;
        commit = onehot && match && (cnt_q == STB - 4'd1);
        bcd_d = bcd_q;
        valid_d = valid_q;
        for (int i = 0; i < NDIG; i++) begin
            if (commit && dig_sel[i]) begin
                if (legal) bcd_d[4*i +: 4] = dec;
                valid_d[i] = legal;
            end
        end
        upd_d = commit;
        // an illegal commit outranks a simultaneous clear
        err_d = (commit && !legal && !blank) || (err_q && !err_clr);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            cnt_q <= '0;
            bcd_q <= '0;
            valid_q <= '0;
            upd_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            cnt_q <= cnt_d;
            bcd_q <= bcd_d;
            valid_q <= valid_d;
            upd_q <= upd_d;
            err_q <= err_d;
        end
    end
    assign bcd = bcd_q;
    assign valid = valid_q;
    assign all_valid = &valid_q;
    assign upd = upd_q;
    assign err = err_q;
endmodule

// File: tb/tb_seg_to_bcd_capture.sv
// tb_seg_to_bcd_capture: directed scenarios plus random scanning checked against a run-length model
module tb_seg_to_bcd_capture;
    localparam int STB = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = 7'h00;
    logic [3:0]  dig_sel = 4'h0;
    logic        err_clr = 1'b0;
    logic [15:0] bcd;
    logic [3:0]  valid;
    logic        all_valid, upd, err;
    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    logic [6:0]  pats [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h1F, 7'h70, 7'h7F, 7'h73};
    logic [15:0] bcd_m = '0;
    logic [3:0]  valid_m = '0;
    logic        upd_m = 1'b0, err_m = 1'b0;
    logic [10:0] last_m = '0;
    int          run_m = 0;

    seg_to_bcd_capture #(.STABLE(STB)) dut (
        .clk(clk), .rst(rst), .seg(seg), .dig_sel(dig_sel), .err_clr(err_clr),
        .bcd(bcd), .valid(valid), .all_valid(all_valid), .upd(upd), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: a digit commits when the same one-hot {dig_sel,seg} has been seen
    // on exactly STB consecutive edges since the last change or reset.
    task automatic model_edge();
        logic [10:0] cur;
        int idx, k;
        bit commit, illegal;
        cur = {dig_sel, seg};
        if (rst) begin
            bcd_m = '0; valid_m = '0; upd_m = 0; err_m = 0; last_m = '0; run_m = 0;
            return;
        end
        run_m = (cur == last_m) ? run_m + 1 : 1;
        last_m = cur;
        commit = ($countones(dig_sel) == 1) && (run_m == STB);
        idx = -1;
        for (int p = 0; p < 10; p++) if (pats[p] == seg) idx = p;
        illegal = (idx < 0) && (seg != 7'h00);
        k = 0;
        for (int b = 0; b < 4; b++) if (dig_sel[b]) k = b;
        upd_m = commit;
        if (commit) begin
            if (idx >= 0) bcd_m[4*k +: 4] = 4'(idx);
            valid_m[k] = idx >= 0;
        end
        err_m = (commit && illegal) ? 1'b1 : err_clr ? 1'b0 : err_m;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("bcd", 32'(bcd), 32'(bcd_m));
        check("valid", 32'(valid), 32'(valid_m));
        check("all_valid", 32'(all_valid), 32'(&valid_m));
        check("upd", 32'(upd), 32'(upd_m));
        check("err", 32'(err), 32'(err_m));
        if (upd) upd_cnt++;
    endtask

    task automatic hold(input logic [3:0] ds, input logic [6:0] sg, input int n);
        dig_sel = ds;
        seg = sg;
        repeat (n) step();
    endtask

    initial begin
        logic [3:0] vsave;
        int first;
        repeat (2) step();
        check("reset_bcd", 32'(bcd), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        rst = 1'b0;
        upd_cnt = 0;
        hold(4'b0001, 7'h5B, 6);
        check("single_upd_count", upd_cnt, 1);
        check("single_digit", 32'(bcd[3:0]), 32'h5);
        check("single_valid", 32'(valid), 32'h1);
        upd_cnt = 0;
        hold(4'b1000, 7'h30, 5);
        hold(4'b0100, 7'h6D, 5);
        hold(4'b0010, 7'h79, 5);
        hold(4'b0001, 7'h33, 5);
        check("scan_bcd", 32'(bcd), 32'h1234);
        check("scan_all_valid", 32'(all_valid), 32'h1);
        check("scan_upd_count", upd_cnt, 4);
        upd_cnt = 0;
        hold(4'b0001, 7'h7E, 3);
        hold(4'b0001, 7'h7F, 1);
        hold(4'b0001, 7'h7E, 4);
        check("glitch_upd_count", upd_cnt, 1);
        check("glitch_digit", 32'(bcd[3:0]), 32'h0);
        hold(4'b0001, 7'h7F, 4);
        hold(4'b0001, 7'h6F, 4);
        check("illegal_digit", 32'(bcd[3:0]), 32'h8);
        check("illegal_valid", 32'(valid[0]), 32'h0);
        check("illegal_err", 32'(err), 32'h1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("err_clr", 32'(err), 32'h0);
        vsave = valid;
        upd_cnt = 0;
        hold(4'b0011, 7'h7E, 10);
        check("multihot_upd", upd_cnt, 0);
        check("multihot_valid", 32'(valid), 32'(vsave));
        hold(4'b0000, 7'h00, 5);
        check("zero_sel_upd", upd_cnt, 0);
        hold(4'b0100, 7'h5B, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_bcd", 32'(bcd), 32'h0);
        check("midrst_valid", 32'(valid), 32'h0);
        check("midrst_err", 32'(err), 32'h0);
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (upd && first == 0) first = i;
        end
        check("midrst_commit_edge", first, STB);
        repeat (250) begin
            dig_sel = ($urandom_range(0, 9) < 7) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            case ($urandom_range(0, 9))
                7: seg = 7'h00;
                8, 9: seg = 7'($urandom_range(0, 127));
                default: seg = pats[$urandom_range(0, 9)];
            endcase
            repeat ($urandom_range(1, 7)) begin
                err_clr = $urandom_range(0, 15) == 0;
                rst = $urandom_range(0, 63) == 0;
                step();
            end
            err_clr = 1'b0;
            rst = 1'b0;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
